// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - registered N-way arbiter, fixed-priority or round-robin with optional hold limit
module rr_arbiter #(
    parameter int N        = 8,
    parameter int RR_MODE  = 1,
    parameter int MAX_HOLD = 0,
    parameter int IDX_W    = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic             forced
);

    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state, state_d;
    logic [N-1:0]      grant_d;
    logic [IDX_W-1:0]  idx_d;
    logic [IDX_W-1:0]  ptr, ptr_d;
    logic [HOLD_W-1:0] cnt, cnt_d;
    logic              forced_d;
    logic [N-1:0]      others;
    logic [N-1:0]      cand;
    logic [IDX_W-1:0]  base;
    logic [IDX_W-1:0]  win;
    logic              take;

    // First set bit of v scanning upward from p, wrapping N-1 -> 0.
    function automatic logic [IDX_W-1:0] pick(input logic [N-1:0] v, input logic [IDX_W-1:0] p);
        logic [IDX_W-1:0] r;
        logic [IDX_W-1:0] jj;
        logic             found;
        r     = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            jj = IDX_W'((int'(p) + k) % N);
            if (!found && v[jj]) begin
                r     = jj;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return IDX_W'((int'(i) + 1) % N);
    endfunction

    always_comb begin
        state_d  = state;
        grant_d  = grant;
        idx_d    = grant_idx;
        ptr_d    = ptr;
        cnt_d    = cnt;
        forced_d = 1'b0;
        others   = req & ~grant;
        cand     = req;
        base     = (RR_MODE != 0) ? ptr : '0;
        take     = 1'b0;
        case (state)
            IDLE: take = |req;
            BUSY: begin
                if (req[grant_idx]) begin
                    if (MAX_HOLD != 0 && cnt == HOLD_LAST) begin
                        // Limit reached: hand over only if someone else is waiting.
                        if (|others) begin
                            take     = 1'b1;
                            cand     = others;
                            base     = (RR_MODE != 0) ? next_idx(grant_idx) : '0;
                            forced_d = 1'b1;
                        end else begin
                            cnt_d = '0;
                        end
                    end else if (cnt != '1) begin
                        cnt_d = cnt + HOLD_W'(1);
                    end
                end else if (|req) begin
                    take = 1'b1;
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        win = pick(cand, base);
        if (take) begin
            state_d = BUSY;
            grant_d = N'(1) << win;
            idx_d   = win;
            cnt_d   = '0;
            if (RR_MODE != 0) ptr_d = next_idx(win);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= '0;
            grant_idx <= '0;
            forced    <= 1'b0;
            ptr       <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_d;
            grant     <= grant_d;
            grant_idx <= idx_d;
            forced    <= forced_d;
            ptr       <= ptr_d;
            cnt       <= cnt_d;
        end
    end

    assign grant_valid = |grant;

endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - checks three arbiter configurations against a behavioural owner/tenure model
module tb_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req_a    [3];
    logic [7:0] grant_a  [3];
    logic       valid_a  [3];
    logic [2:0] idx_a    [3];
    logic       forced_a [3];

    int n_cmp = 0;
    int n_bad = 0;

    // Instance 0: fixed priority; 1: round-robin unlimited; 2: round-robin, hold limit 4.
    int         m_owner  [3];
    int         m_ptr    [3];
    int         m_ten    [3];
    bit         m_forced [3];
    logic [7:0] m_prev   [3];

    initial forever #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        rr_arbiter #(
            .N(8),
            .RR_MODE((g == 0) ? 0 : 1),
            .MAX_HOLD((g == 2) ? 4 : 0)
        ) u_dut (
            .clk(clk),
            .rst_n(rst_n),
            .req(req_a[g]),
            .grant(grant_a[g]),
            .grant_valid(valid_a[g]),
            .grant_idx(idx_a[g]),
            .forced(forced_a[g])
        );
    end

    function automatic int first_from(input logic [7:0] v, input int p);
        logic [7:0] s;
        for (int k = 0; k < 8; k++) begin
            s = v >> ((p + k) % 8);
            if (s[0]) return (p + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int g = 0; g < 3; g++) begin
            m_owner[g]  = -1;
            m_ptr[g]    = 0;
            m_ten[g]    = 0;
            m_forced[g] = 1'b0;
        end
    endtask

    task automatic grant_to(input int g, input int i);
        m_owner[g] = i;
        m_ten[g]   = 1;
        if (g != 0) m_ptr[g] = (i + 1) % 8;
    endtask

    // Tenure counts cycles the current owner has already held the grant.
    task automatic model_step(input int g, input logic [7:0] r);
        logic [7:0] own;
        int         lim;
        bit         rr;
        rr  = (g != 0);
        lim = (g == 2) ? 4 : 0;
        m_forced[g] = 1'b0;
        if (m_owner[g] < 0) begin
            if (r != 0) grant_to(g, first_from(r, rr ? m_ptr[g] : 0));
        end else begin
            own = 8'(1) << m_owner[g];
            if ((r & own) != 0) begin
                if (lim > 0 && m_ten[g] == lim) begin
                    if ((r & ~own) != 0) begin
                        grant_to(g, first_from(r & ~own, rr ? (m_owner[g] + 1) % 8 : 0));
                        m_forced[g] = 1'b1;
                    end else begin
                        m_ten[g] = 1;
                    end
                end else begin
                    m_ten[g]++;
                end
            end else if (r != 0) begin
                grant_to(g, first_from(r, rr ? m_ptr[g] : 0));
            end else begin
                m_owner[g] = -1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int g = 0; g < 3; g++) begin
            m_prev[g] = req_a[g];
            model_step(g, req_a[g]);
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        for (int g = 0; g < 3; g++) req_a[g] = 8'h00;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int g = 0; g < 3; g++) req_a[g] = 8'hFF;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            n_cmp++;
            if (grant_a[g] !== 8'h00 || valid_a[g] !== 1'b0 || idx_a[g] !== 3'd0 || forced_a[g] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_hold[%0d]: got grant=%h valid=%b idx=%0d forced=%b required 00/0/0/0",
                         g, grant_a[g], valid_a[g], idx_a[g], forced_a[g]);
            end
        end
        rst_n = 1'b1;
        tick();
        for (int g = 0; g < 3; g++) begin
            n_cmp++;
            if (grant_a[g] !== 8'h01 || valid_a[g] !== 1'b1 || idx_a[g] !== 3'd0) begin
                n_bad++;
                $display("FAIL reset_release[%0d]: got grant=%h valid=%b idx=%0d required 01/1/0",
                         g, grant_a[g], valid_a[g], idx_a[g]);
            end
        end
    endtask

    task automatic test_fixed_priority();
        logic [7:0] reqs [3];
        logic [7:0] exps [3];
        reqs = '{8'b1010_0100, 8'b1010_0000, 8'b1000_0000};
        exps = '{8'b0000_0100, 8'b0010_0000, 8'b1000_0000};
        apply_reset();
        for (int s = 0; s < 3; s++) begin
            req_a[0] = reqs[s];
            tick();
            n_cmp++;
            if (grant_a[0] !== exps[s] || valid_a[0] !== 1'b1) begin
                n_bad++;
                $display("FAIL fixed_step%0d: got grant=%h valid=%b required %h/1", s, grant_a[0], valid_a[0], exps[s]);
            end
        end
    endtask

    task automatic test_rr_rotation();
        apply_reset();
        req_a[1] = 8'hFF;
        tick();
        n_cmp++;
        if (idx_a[1] !== 3'd0 || grant_a[1] !== 8'h01) begin
            n_bad++;
            $display("FAIL rr_first: got idx=%0d grant=%h required 0/01", idx_a[1], grant_a[1]);
        end
        for (int k = 1; k <= 9; k++) begin
            req_a[1] = ~(8'(1) << ((k - 1) % 8));
            tick();
            n_cmp++;
            if (idx_a[1] !== 3'(k % 8) || grant_a[1] !== (8'(1) << (k % 8)) || valid_a[1] !== 1'b1) begin
                n_bad++;
                $display("FAIL rr_rotate%0d: got idx=%0d grant=%h valid=%b required idx %0d",
                         k, idx_a[1], grant_a[1], valid_a[1], k % 8);
            end
        end
    endtask

    task automatic test_hold_limit();
        logic [7:0] exp_g;
        logic       exp_f;
        apply_reset();
        req_a[2] = 8'h03;
        for (int t = 1; t <= 9; t++) begin
            tick();
            exp_g = (t <= 4) ? 8'h01 : (t <= 8) ? 8'h02 : 8'h01;
            exp_f = (t == 5 || t == 9);
            n_cmp++;
            if (grant_a[2] !== exp_g || forced_a[2] !== exp_f) begin
                n_bad++;
                $display("FAIL hold_cycle%0d: got grant=%h forced=%b required %h/%b",
                         t, grant_a[2], forced_a[2], exp_g, exp_f);
            end
        end
        req_a[2] = 8'h01;
        for (int t = 0; t < 12; t++) begin
            tick();
            n_cmp++;
            if (grant_a[2] !== 8'h01 || forced_a[2] !== 1'b0) begin
                n_bad++;
                $display("FAIL hold_alone%0d: got grant=%h forced=%b required 01/0", t, grant_a[2], forced_a[2]);
            end
        end
    endtask

    task automatic test_release_idle();
        apply_reset();
        req_a[1] = 8'h08;
        tick();
        n_cmp++;
        if (grant_a[1] !== 8'h08) begin
            n_bad++;
            $display("FAIL idle_grant3: got %h required 08", grant_a[1]);
        end
        req_a[1] = 8'h00;
        tick();
        n_cmp++;
        if (grant_a[1] !== 8'h00 || valid_a[1] !== 1'b0 || idx_a[1] !== 3'd0) begin
            n_bad++;
            $display("FAIL idle_release: got grant=%h valid=%b idx=%0d required 00/0/0", grant_a[1], valid_a[1], idx_a[1]);
        end
        req_a[1] = 8'h09;
        tick();
        n_cmp++;
        if (grant_a[1] !== 8'h01) begin
            n_bad++;
            $display("FAIL idle_ptr_wrap: got %h required 01", grant_a[1]);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        req_a[1] = 8'h10;
        tick();
        n_cmp++;
        if (grant_a[1] !== 8'h10) begin
            n_bad++;
            $display("FAIL async_pre: got %h required 10", grant_a[1]);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (grant_a[1] !== 8'h00 || valid_a[1] !== 1'b0 || idx_a[1] !== 3'd0) begin
            n_bad++;
            $display("FAIL async_clear: got grant=%h valid=%b idx=%0d required 00/0/0", grant_a[1], valid_a[1], idx_a[1]);
        end
        @(negedge clk);
        req_a[1] = 8'h30;
        rst_n    = 1'b1;
        tick();
        n_cmp++;
        if (grant_a[1] !== 8'h10) begin
            n_bad++;
            $display("FAIL async_ptr_reset: got %h required 10", grant_a[1]);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_g;
        int         exp_i;
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            for (int g = 0; g < 3; g++) begin
                case ($urandom_range(0, 7))
                    0:       req_a[g] = 8'($urandom);
                    1:       req_a[g] = req_a[g] & 8'($urandom);
                    2:       req_a[g] = req_a[g] | 8'($urandom_range(0, 255));
                    3:       req_a[g] = ($urandom_range(0, 3) == 0) ? 8'h00 : req_a[g];
                    default: req_a[g] = req_a[g];
                endcase
            end
            tick();
            for (int g = 0; g < 3; g++) begin
                exp_i = (m_owner[g] < 0) ? 0 : m_owner[g];
                exp_g = (m_owner[g] < 0) ? 8'h00 : (8'(1) << m_owner[g]);
                n_cmp++;
                if (grant_a[g] !== exp_g || idx_a[g] !== 3'(exp_i) || valid_a[g] !== (m_owner[g] >= 0)
                    || forced_a[g] !== m_forced[g]) begin
                    n_bad++;
                    $display("FAIL rand_c%0d_i%0d: got grant=%h idx=%0d valid=%b forced=%b required %h/%0d/%b/%b",
                             c, g, grant_a[g], idx_a[g], valid_a[g], forced_a[g],
                             exp_g, exp_i, (m_owner[g] >= 0), m_forced[g]);
                end
                n_cmp++;
                if (!$onehot0(grant_a[g]) || (grant_a[g] & ~m_prev[g]) !== 8'h00) begin
                    n_bad++;
                    $display("FAIL rand_inv_c%0d_i%0d: got grant=%h with prior req=%h required one-hot subset",
                             c, g, grant_a[g], m_prev[g]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fixed_priority();
        test_rr_rotation();
        test_hold_limit();
        test_release_idle();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Parametrised, registered successor to the team's 8-bit combinational fixed-priority arbiter.
- Arbitrates N request lines and produces one-hot grants.
- Mode is selectable: fixed priority (bit 0 highest) or round-robin.
- Holds a grant while the owner keeps requesting, with an optional hold limit that forces rotation.
- Sits in front of shared resources (bus, memory port, audio/display source) where several clients contend.

Parameters:
N, 8, number of requesters (2..32)
RR_MODE, 1, 1 = round-robin priority rotation; 0 = fixed priority, bit 0 highest
MAX_HOLD, 0, maximum consecutive cycles one owner may keep the grant while others wait; 0 = unlimited
IDX_W, $clog2(N), width of grant_idx (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req  input  N  request vector; bit i = client i requests
grant  output  N  registered one-hot grant; all-zero when idle
grant_valid  output  1  high whenever grant is non-zero
grant_idx  output  IDX_W  binary index of the granted client; 0 when idle
forced  output  1  one-cycle pulse; grant was taken from a still-requesting owner by MAX_HOLD

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; grant = 0; grant_valid = 0; grant_idx = 0; forced = 0; priority pointer ptr = 0; hold counter = 0. Outputs update immediately on reset assertion, mid-grant included. Release is synchronous to the next clk edge.
- All outputs are registered. Grant appears 1 cycle after the req edge that causes it. No combinational path from req to grant.
- pick(v, p): the first set bit of v, scanning from index p upward and wrapping N-1 -> 0.
  - RR_MODE=0: p is always 0, giving exact fixed-priority behaviour (lowest index wins).
- IDLE state:
  - req == 0: stay IDLE; outputs stay 0.
  - req != 0: grant <= onehot(pick(req, ptr)); go to BUSY; hold counter <= 0.
- BUSY state, owner o:
  - req[o]=1, and either the hold limit is not reached or no other req bit is set: keep the grant; hold counter += 1 (saturates).
  - req[o]=1, MAX_HOLD != 0, hold counter == MAX_HOLD-1, and another req bit is set: regrant pick(req & ~onehot(o), o+1); forced <= 1 for that cycle; hold counter <= 0.
  - req[o]=0 and other requests pending: regrant pick(req, ptr) on the same edge. No idle bubble. grant_valid stays 1.
  - req[o]=0 and req == 0: go to IDLE; grant <= 0.
  - Only the owner requesting at the limit: owner keeps the grant; counter resets to 0; forced stays 0.
- Pointer update (RR_MODE=1 only): on every new grant to index i, ptr <= (i+1) mod N. i = N-1 wraps ptr to 0. Re-grants of the same owner do not move ptr.
- Simultaneous events:
  - Owner drop and new request on the same edge: the new request competes normally.
  - Multiple new requests on the same edge: exactly one grant bit.
- Invariants:
  - grant is always zero or one-hot.
  - grant_idx always matches grant.
  - grant_valid == |grant.
  - A granted bit implies its req was high on the preceding edge.
- Fairness (RR_MODE=1): a continuously requesting client is granted within N-1 ownership changes. With MAX_HOLD = H, its wait is bounded by (N-1)*H cycles plus latency.
- X on req is not handled specially. Benches drive only 0/1.

Test Plan:
- Reset/idle: hold rst_n=0 with req=8'hFF; release -> grant=0 during reset; grant=8'h01 and grant_idx=0 one cycle after release; grant_valid=1.
- Fixed priority (RR_MODE=0): req=8'b1010_0100 -> grant=8'b0000_0100. Drop bit 2 -> grant=8'b0010_0000 next cycle, no bubble. Drop bit 5 -> grant=8'h80.
- Round-robin rotation (RR_MODE=1): req=8'hFF; each owner drops its req for one cycle after receiving its grant. Required grant_idx sequence: 0,1,2,...,7,0, with wrap from 7 to 0 and the ptr update checked.
- Hold limit (MAX_HOLD=4): req=8'b0000_0011 held constant. Required: client 0 granted for 4 cycles, then grant=8'h02 with a forced pulse; client 1 for 4 cycles, then back to 8'h01. With req=8'h01 only: grant stays 8'h01 indefinitely and forced never pulses.
- Release to idle: owner 3 alone drops its req -> grant=0 and grant_valid=0 next cycle. A subsequent req=8'h09 -> grant=8'h01 because ptr=4 wraps to bit 0.
- Mid-grant async reset: assert rst_n=0 between clock edges while grant=8'h10 -> grant=0 without a clock edge. After release with req=8'h30 -> grant=8'h10 because ptr reset to 0.
